// File: rtl/hs32_fetch.sv
// hs32_fetch: instruction fetch stage with PC, single-outstanding memory reads,
// a prefetch FIFO towards decode, and flush/redirect handling from execute.
module hs32_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] addr,
    output logic        mreq,
    input  logic        mack,
    input  logic [31:0] mdat,
    input  logic        flush,
    input  logic [31:0] newpc,
    output logic [31:0] instd,
    output logic        ackd,
    input  logic        reqd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    state_t        r_state, w_state_n;
    logic [31:0]   r_pc, r_addr, r_instd, w_pc_n, w_addr_n, w_instd_n, w_head_n;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rptr, r_wptr, w_rptr_n, w_wptr_n;
    logic [CW-1:0] r_count, w_count_n, w_count_pop;
    logic          w_ack, w_push, w_pop, w_space;
    assign mreq  = r_state != IDLE;
    assign addr  = r_addr;
    assign ackd  = r_count != '0;
    assign instd = r_instd;
    always_comb begin
        w_ack       = mack && r_state != IDLE;
        w_push      = mack && r_state == REQ && !flush;
        w_pop       = ackd && reqd && !flush;
        w_count_pop = r_count - CW'(w_pop);
        w_count_n   = flush ? '0 : w_count_pop + CW'(w_push);
        w_rptr_n    = flush ? '0 : r_rptr + AW'(w_pop);
        w_wptr_n    = flush ? '0 : r_wptr + AW'(w_push);
        w_space     = w_count_n < CW'(FIFO_DEPTH);
        w_pc_n      = flush ? (newpc & ~32'd3) : (mack && r_state == REQ) ? r_pc + 32'd4 : r_pc;
        w_state_n   = r_state;
        case (r_state)
            IDLE:    w_state_n = w_space ? REQ : IDLE;
            REQ:     w_state_n = w_ack ? (w_space ? REQ : IDLE) : (flush ? DISCARD : REQ);
            DISCARD: w_state_n = w_ack ? REQ : DISCARD;
            default: w_state_n = IDLE;
        endcase
        // DISCARD keeps the stale request on the bus until memory answers it
        w_addr_n    = (w_state_n == DISCARD) ? r_addr : w_pc_n;
        w_head_n    = (w_count_pop == '0) ? mdat : r_mem[w_rptr_n];
        w_instd_n   = (w_count_n != '0) ? w_head_n : r_instd;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_count <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_instd <= '0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_addr  <= w_addr_n;
            r_count <= w_count_n;
            r_rptr  <= w_rptr_n;
            r_wptr  <= w_wptr_n;
            r_instd <= w_instd_n;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= mdat;
    end
endmodule

// File: tb/tb_hs32_fetch.sv
// tb_hs32_fetch: directed stimulus with a memory responder; expected instruction
// words are queued on issue and checked by a separate monitor on decode pops.
module tb_hs32_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr, mdat = '0, newpc = '0, instd;
    logic        mreq, mack = 1'b0, flush = 1'b0, ackd, reqd = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    hs32_fetch #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(rst_n), .addr(addr), .mreq(mreq), .mack(mack), .mdat(mdat),
        .flush(flush), .newpc(newpc), .instd(instd), .ackd(ackd), .reqd(reqd)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n || flush) exp_q.delete();
        else if (ackd && reqd) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL instd_unexpected: got %h expected no word", instd);
            end else check("instd", instd, exp_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // answers the current request after lat wait cycles with data d
    task automatic serve(input logic [31:0] ea, input logic [31:0] d, input int lat,
                         input bit deliver, input bit chk_ack);
        int n = 0;
        while (!mreq && n < 20) begin
            tick();
            n++;
        end
        check("mreq_wait", mreq, 1);
        check("addr", addr, ea);
        repeat (lat) begin
            tick();
            check("addr_hold", {mreq, addr}, {1'b1, ea});
        end
        mack = 1'b1;
        mdat = d;
        if (deliver) exp_q.push_back(d);
        tick();
        mack = 1'b0;
        mdat = 32'hDEAD_BEEF;
        if (chk_ack) check("ackd_latency", ackd, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_mreq", mreq, 0);
        check("rst_ackd", ackd, 0);
        check("rst_instd", instd, 0);
        check("rst_addr", addr, 32'h100);
        rst_n = 1'b1;
        tick();
        check("first_mreq", {mreq, addr}, {1'b1, 32'h100});
        // sequential fetch with decode always ready
        reqd = 1'b1;
        serve(32'h100, 32'hA000_0001, 1, 1, 1);
        serve(32'h104, 32'hA000_0002, 1, 1, 1);
        serve(32'h108, 32'hA000_0003, 1, 1, 1);
        // decode stalls: FIFO fills to 2 and issuing stops
        reqd = 1'b0;
        serve(32'h10C, 32'hB000_0001, 1, 1, 0);
        check("full_mreq", mreq, 0);
        check("full_head", {ackd, instd}, {1'b1, 32'hA000_0003});
        repeat (2) begin
            tick();
            check("full_hold", {mreq, ackd, instd}, {2'b01, 32'hA000_0003});
        end
        reqd = 1'b1;
        tick();
        check("resume", {mreq, addr, instd}, {1'b1, 32'h110, 32'hB000_0001});
        tick();
        // flush while 0x110 outstanding
        flush = 1'b1;
        newpc = 32'h2002;
        tick();
        flush = 1'b0;
        check("discard_hold", {mreq, addr}, {1'b1, 32'h110});
        serve(32'h110, 32'hC000_0001, 1, 0, 0);
        check("after_discard", {mreq, ackd, addr}, {2'b10, 32'h2000});
        // flush coincident with mack
        serve(32'h2000, 32'hD000_0001, 1, 1, 1);
        check("pre_coinc", addr, 32'h2004);
        mack = 1'b1;
        mdat = 32'hD000_0002;
        flush = 1'b1;
        newpc = 32'h3000;
        tick();
        mack = 1'b0;
        flush = 1'b0;
        check("coinc_flush", {mreq, ackd, addr}, {2'b10, 32'h3000});
        serve(32'h3000, 32'hE000_0001, 1, 1, 1);
        // pc wrap at top of address space
        mack = 1'b1;
        mdat = 32'h1234_5678;
        flush = 1'b1;
        newpc = 32'hFFFF_FFFF;
        tick();
        mack = 1'b0;
        flush = 1'b0;
        check("wrap_pre", addr, 32'hFFFF_FFFC);
        serve(32'hFFFF_FFFC, 32'hF000_0001, 0, 1, 1);
        check("wrap", {mreq, addr}, {1'b1, 32'h0});
        // reset mid-read with one word buffered
        reqd = 1'b0;
        tick();
        check("pre_reset", {ackd, instd}, {1'b1, 32'hF000_0001});
        #2 rst_n = 1'b0;
        #1;
        check("midrst", {mreq, ackd, instd, addr}, {2'b00, 32'h0, 32'h100});
        tick();
        rst_n = 1'b1;
        mack = 1'b1;
        mdat = 32'h5555_AAAA;
        tick();
        mack = 1'b0;
        check("late_mack", {mreq, ackd, addr}, {2'b10, 32'h100});
        reqd = 1'b1;
        serve(32'h100, 32'h6000_0001, 1, 1, 1);
        repeat (3) tick();
        check("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
